// File: rtl/lc3_writeback.sv
// LC3 writeback stage: result-source mux, 2**ADDR_WIDTH-entry register file and NZP condition codes.
// Optional macro LC3_WB_BYPASS_EN forwards write data to VSR1/VSR2 during the writing cycle.
module lc3_writeback #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_writeback,
    input  logic [1:0]            W_Control,
    input  logic [DATA_WIDTH-1:0] aluout,
    input  logic [DATA_WIDTH-1:0] memout,
    input  logic [DATA_WIDTH-1:0] pcout,
    input  logic [DATA_WIDTH-1:0] npc,
    input  logic [ADDR_WIDTH-1:0] sr1,
    input  logic [ADDR_WIDTH-1:0] sr2,
    input  logic [ADDR_WIDTH-1:0] dr,
    output logic [DATA_WIDTH-1:0] VSR1,
    output logic [DATA_WIDTH-1:0] VSR2,
    output logic [2:0]            psr
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [2:0]            psr_q;
    logic [2:0]            psr_d;
    logic [DATA_WIDTH-1:0] dr_in;

    always_comb begin
        dr_in = aluout;
        unique case (W_Control)
            2'd0: dr_in = aluout;
            2'd1: dr_in = memout;
            2'd2: dr_in = pcout;
            2'd3: dr_in = npc;
        endcase
    end

    // Exactly one of N/Z/P is set for any written value.
    always_comb begin
        psr_d = {dr_in[DATA_WIDTH-1],
                 dr_in == '0,
                 !dr_in[DATA_WIDTH-1] && (dr_in != '0)};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            psr_q <= 3'b000;
        end else if (enable_writeback) begin
            regs_q[dr] <= dr_in;
            psr_q      <= psr_d;
        end
    end

    always_comb begin
        VSR1 = regs_q[sr1];
        VSR2 = regs_q[sr2];
`ifdef LC3_WB_BYPASS_EN
        // Write-through: a reader of the register being written sees the new value now.
        if (enable_writeback && !reset) begin
            if (sr1 == dr) begin
                VSR1 = dr_in;
            end
            if (sr2 == dr) begin
                VSR2 = dr_in;
            end
        end
`endif
    end

    assign psr = psr_q;

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: directed literal checks plus randomized traffic
// compared every cycle against a behavioural register-file model.
module tb_lc3_writeback;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_writeback = 1'b0;
    logic [1:0]  W_Control = 2'd0;
    logic [15:0] aluout = '0, memout = '0, pcout = '0, npc = '0;
    logic [2:0]  sr1 = '0, sr2 = '0, dr = '0;
    logic [15:0] VSR1, VSR2;
    logic [2:0]  psr;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    lc3_writeback #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable_writeback (enable_writeback),
        .W_Control        (W_Control),
        .aluout           (aluout),
        .memout           (memout),
        .pcout            (pcout),
        .npc              (npc),
        .sr1              (sr1),
        .sr2              (sr2),
        .dr               (dr),
        .VSR1             (VSR1),
        .VSR2             (VSR2),
        .psr              (psr)
    );

    always #5 clock = ~clock;

`ifdef LC3_WB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    // Behavioural model: an array of register values and the last-written flags.
    logic [15:0] mreg [8];
    logic [2:0]  mpsr;

    function automatic logic [15:0] src_value();
        logic [15:0] srcs [4];
        srcs[0] = aluout;
        srcs[1] = memout;
        srcs[2] = pcout;
        srcs[3] = npc;
        return srcs[W_Control];
    endfunction

    function automatic logic [2:0] flags_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [15:0] exp_read(input logic [2:0] sel);
        if (reset) return 16'h0000;
        if (Bypass && enable_writeback && sel == dr) return src_value();
        return mreg[sel];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mreg[i] <= 16'h0000;
            mpsr <= 3'b000;
        end else if (enable_writeback) begin
            mreg[dr] <= src_value();
            mpsr     <= flags_of(src_value());
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("model_vsr1", VSR1, exp_read(sr1));
            check("model_vsr2", VSR2, exp_read(sr2));
            check("model_psr", {13'd0, psr}, {13'd0, mpsr});
        end
    end

    task automatic drive(input logic en, input logic [1:0] wc, input logic [15:0] val,
                         input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
        @(posedge clock);
        #1;
        enable_writeback = en;
        W_Control = wc;
        aluout = 16'h0000;
        memout = 16'h0000;
        pcout  = 16'h0000;
        npc    = 16'h0000;
        case (wc)
            2'd0: aluout = val;
            2'd1: memout = val;
            2'd2: pcout  = val;
            default: npc = val;
        endcase
        sr1 = s1;
        sr2 = s2;
        dr  = d;
    endtask

    initial begin
        check_en = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Post-reset sweep of every register.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'd0, 16'h0000, 3'(i), 3'(7 - i), 3'd0);
            @(negedge clock);
            check("reset_vsr1", VSR1, 16'h0000);
            check("reset_vsr2", VSR2, 16'h0000);
            check("reset_psr", {13'd0, psr}, 16'h0000);
        end

        drive(1'b1, 2'd0, 16'h8001, 3'd0, 3'd0, 3'd3);
        drive(1'b0, 2'd0, 16'h0000, 3'd3, 3'd3, 3'd0);
        @(negedge clock);
        check("alu_write_r3", VSR1, 16'h8001);
        check("alu_psr_n", {13'd0, psr}, 16'h0004);

        drive(1'b1, 2'd1, 16'h0000, 3'd4, 3'd4, 3'd0);
        drive(1'b1, 2'd2, 16'h1234, 3'd4, 3'd4, 3'd1);
        @(negedge clock);
        check("mem_psr_z", {13'd0, psr}, 16'h0002);
        drive(1'b1, 2'd3, 16'h3001, 3'd4, 3'd4, 3'd2);
        @(negedge clock);
        check("pc_psr_p", {13'd0, psr}, 16'h0001);
        drive(1'b0, 2'd0, 16'h0000, 3'd0, 3'd1, 3'd0);
        @(negedge clock);
        check("npc_psr_p", {13'd0, psr}, 16'h0001);
        check("mem_r0", VSR1, 16'h0000);
        check("pc_r1", VSR2, 16'h1234);
        drive(1'b0, 2'd0, 16'h0000, 3'd2, 3'd3, 3'd0);
        @(negedge clock);
        check("npc_r2", VSR1, 16'h3001);

        drive(1'b0, 2'd0, 16'hFFFF, 3'd0, 3'd0, 3'd5);
        drive(1'b0, 2'd0, 16'h0000, 3'd5, 3'd5, 3'd0);
        @(negedge clock);
        check("disabled_r5", VSR1, 16'h0000);
        check("disabled_psr", {13'd0, psr}, 16'h0001);

        drive(1'b1, 2'd0, 16'h0011, 3'd0, 3'd0, 3'd4);
        drive(1'b1, 2'd0, 16'h00AA, 3'd4, 3'd0, 3'd4);
        @(negedge clock);
        check("rdw_same_cycle", VSR1, Bypass ? 16'h00AA : 16'h0011);
        drive(1'b0, 2'd0, 16'h0000, 3'd4, 3'd4, 3'd0);
        @(negedge clock);
        check("rdw_next_cycle", VSR1, 16'h00AA);

        drive(1'b1, 2'd0, 16'h7777, 3'd0, 3'd0, 3'd7);
        drive(1'b0, 2'd0, 16'h0000, 3'd7, 3'd7, 3'd0);
        @(negedge clock);
        check("r7_written", VSR1, 16'h7777);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_vsr1", VSR1, 16'h0000);
        check("async_reset_psr", {13'd0, psr}, 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Randomized traffic; data goes to X while writes are disabled.
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] v;
            logic        en;
            case ($urandom_range(0, 3))
                0: v = 16'h0000;
                1: v = 16'h8000 | 16'($urandom);
                default: v = 16'($urandom);
            endcase
            en = ($urandom_range(0, 3) != 0);
            drive(en, 2'($urandom), v, 3'($urandom), 3'($urandom), 3'($urandom));
            if (!en && $urandom_range(0, 3) == 0) begin
                aluout = 'x;
                memout = 'x;
                pcout  = 'x;
                npc    = 'x;
            end
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b1;
                @(posedge clock);
                #3;
                reset = 1'b0;
            end
        end

        @(negedge clock);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
